axis_endian_bridge: RTL

- Registered, parametrised AXI4-Stream byte-order converter.
- Sits between the MAC-side little-endian stream and the SHA-2 Wt unit. It can reverse bytes across the full bus or within each N-byte word.
- Swap mode is selectable at runtime, latched per packet.
- Two-entry skid buffer gives full throughput with a registered s_axis_tready.

---
 rtl/axis_endian_bridge.sv | 130 +++++++++++++
 1 files changed

// File: rtl/axis_endian_bridge.sv
// axis_endian_bridge: registered AXI4-Stream byte-order converter with a two-entry skid buffer
// Ports: clk, reset (synchronous, active-high); cfg_swap_en picks reversal and is latched per packet;
//   s_axis_* input stream (tready registered); m_axis_* converted output stream, tuser/tlast untouched.
// Optional macro AXIS_ENDIAN_BRIDGE_STATS_EN adds stat_pkt_count and stat_swap_pkt_count outputs.
module axis_endian_bridge #(
  parameter int C_AXIS_DATA_WIDTH  = 512,
  parameter int C_AXIS_TUSER_WIDTH = 128,
  parameter int SWAP_WORD_BYTES    = 64
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           cfg_swap_en,
  input  logic [C_AXIS_DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0] s_axis_tkeep,
  input  logic [C_AXIS_TUSER_WIDTH-1:0]  s_axis_tuser,
  input  logic                           s_axis_tvalid,
  output logic                           s_axis_tready,
  input  logic                           s_axis_tlast,
  output logic [C_AXIS_DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [C_AXIS_DATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic [C_AXIS_TUSER_WIDTH-1:0]  m_axis_tuser,
  output logic                           m_axis_tvalid,
  input  logic                           m_axis_tready,
  output logic                           m_axis_tlast
`ifdef AXIS_ENDIAN_BRIDGE_STATS_EN
  ,
  output logic [31:0]                    stat_pkt_count,
  output logic [31:0]                    stat_swap_pkt_count
`endif
);
  localparam int NB = C_AXIS_DATA_WIDTH / 8;
  localparam int G  = SWAP_WORD_BYTES;
  logic [C_AXIS_DATA_WIDTH-1:0] sw_data, in_data, out_data_q, out_data_d, skid_data_q, skid_data_d;
  logic [NB-1:0] sw_keep, in_keep, out_keep_q, out_keep_d, skid_keep_q, skid_keep_d;
  logic [C_AXIS_TUSER_WIDTH-1:0] out_user_q, out_user_d, skid_user_q, skid_user_d;
  logic out_last_q, out_last_d, skid_last_q, skid_last_d;
  logic out_valid_q, out_valid_d, skid_valid_q, skid_valid_d;
  logic ready_q, in_pkt_q, in_pkt_d, mode_q, mode_d;
  logic acc, xfer, mode, to_out, from_skid, to_skid;
  for (genvar i = 0; i < NB; i++) begin : g_rev
    assign sw_data[8*i +: 8] = s_axis_tdata[8*((i/G)*G + G-1 - i%G) +: 8];
    assign sw_keep[i]        = s_axis_tkeep[(i/G)*G + G-1 - i%G];
  end
  assign acc       = s_axis_tvalid & ready_q;
  assign xfer      = out_valid_q & m_axis_tready;
  // first beat of a packet follows the live config; later beats use the latched mode
  assign mode      = in_pkt_q ? mode_q : cfg_swap_en;
  assign in_data   = mode ? sw_data : s_axis_tdata;
  assign in_keep   = mode ? sw_keep : s_axis_tkeep;
  assign to_out    = acc & (~out_valid_q | (xfer & ~skid_valid_q));
  assign from_skid = xfer & skid_valid_q;
  assign to_skid   = acc & ~to_out;
  always_comb begin
    out_valid_d  = to_out | from_skid | (out_valid_q & ~xfer);
    out_data_d   = to_out ? in_data : from_skid ? skid_data_q : out_data_q;
    out_keep_d   = to_out ? in_keep : from_skid ? skid_keep_q : out_keep_q;
    out_user_d   = to_out ? s_axis_tuser : from_skid ? skid_user_q : out_user_q;
    out_last_d   = to_out ? s_axis_tlast : from_skid ? skid_last_q : out_last_q;
    skid_valid_d = to_skid | (skid_valid_q & ~xfer);
    skid_data_d  = to_skid ? in_data : skid_data_q;
    skid_keep_d  = to_skid ? in_keep : skid_keep_q;
    skid_user_d  = to_skid ? s_axis_tuser : skid_user_q;
    skid_last_d  = to_skid ? s_axis_tlast : skid_last_q;
    in_pkt_d     = acc ? ~s_axis_tlast : in_pkt_q;
    mode_d       = (acc & ~in_pkt_q) ? cfg_swap_en : mode_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_keep_q   <= '0;
      out_user_q   <= '0;
      out_last_q   <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_keep_q  <= '0;
      skid_user_q  <= '0;
      skid_last_q  <= 1'b0;
      ready_q      <= 1'b0;
      in_pkt_q     <= 1'b0;
      mode_q       <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_keep_q   <= out_keep_d;
      out_user_q   <= out_user_d;
      out_last_q   <= out_last_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      skid_keep_q  <= skid_keep_d;
      skid_user_q  <= skid_user_d;
      skid_last_q  <= skid_last_d;
      ready_q      <= ~skid_valid_d;
      in_pkt_q     <= in_pkt_d;
      mode_q       <= mode_d;
    end
  end
  assign s_axis_tready = ready_q;
  assign m_axis_tvalid = out_valid_q;
  assign m_axis_tdata  = out_data_q;
  assign m_axis_tkeep  = out_keep_q;
  assign m_axis_tuser  = out_user_q;
  assign m_axis_tlast  = out_last_q;
`ifdef AXIS_ENDIAN_BRIDGE_STATS_EN
  // each beat carries its own mode so the swap counter sees the packet's mode at its last beat
  logic out_mode_q, out_mode_d, skid_mode_q, skid_mode_d;
  logic [31:0] pkt_q, pkt_d, swp_q, swp_d;
  always_comb begin
    out_mode_d  = to_out ? mode : from_skid ? skid_mode_q : out_mode_q;
    skid_mode_d = to_skid ? mode : skid_mode_q;
    pkt_d       = pkt_q + {31'd0, xfer & out_last_q};
    swp_d       = swp_q + {31'd0, xfer & out_last_q & out_mode_q};
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      out_mode_q  <= 1'b0;
      skid_mode_q <= 1'b0;
      pkt_q       <= '0;
      swp_q       <= '0;
    end else begin
      out_mode_q  <= out_mode_d;
      skid_mode_q <= skid_mode_d;
      pkt_q       <= pkt_d;
      swp_q       <= swp_d;
    end
  end
  assign stat_pkt_count      = pkt_q;
  assign stat_swap_pkt_count = swp_q;
`endif
endmodule
